modred_pipe: RTL and testbench

Parametrised, pipelined word-level modular reducer for NTT-friendly primes (q ≡ 1 mod 2^W). It takes a double-width product P < q·2^DATA_W and returns P·2^(−L·W) mod q, fully reduced into [0, q). The modulus travels with each beat, so back-to-back beats may use different RNS moduli. A valid/ready handshake with whole-pipe stall lets it sit directly behind the NTT butterfly multiplier.

---
 rtl/modred_pipe_pkg.sv | 25 ++
 rtl/modred_stage.sv | 60 ++++++
 rtl/modred_pipe.sv | 128 ++++++++++++
 tb/tb_modred_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modred_pipe_pkg.sv
// Shared defaults and width helpers for the modred_pipe word-level modular reducer.
// Build option: define MODRED_CHECK_EN to carry a per-beat modulus-check error bit.
package modred_pipe_pkg;

    localparam int DATA_W_DEF = 30;
    localparam int W_DEF      = 6;
    localparam int TAG_W_DEF  = 8;

    function automatic int n_stages(input int data_w, input int w);
        return (data_w + w - 1) / w;
    endfunction

    // Width of the running value entering stage k; the +1 absorbs the carry of TH + qH*t + 1.
    function automatic int cw(input int k, input int data_w, input int w);
        int c;
        c = 2 * data_w;
        for (int i = 0; i < k; i++) begin
            c = (((c - w) > data_w) ? (c - w) : data_w) + 1;
        end
        return c;
    endfunction

    localparam int L = n_stages(DATA_W_DEF, W_DEF);

endpackage

// File: rtl/modred_stage.sv
// One word-level reduction step: retires W low bits of T using q = qH*2^W + 1.
// Build option: MODRED_CHECK_EN adds the err sideband bit.
module modred_stage
    import modred_pipe_pkg::*;
#(
    parameter int CURR_W = 60,
    parameter int NEXT_W = 55,
    parameter int DATA_W = 30,
    parameter int W      = 6,
    parameter int TAG_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              valid_in,
    input  logic [CURR_W-1:0] t_in,
    input  logic [DATA_W-1:0] q_in,
    input  logic [TAG_W-1:0]  tag_in,
`ifdef MODRED_CHECK_EN
    input  logic              err_in,
    output logic              err_out,
`endif
    output logic              valid_out,
    output logic [NEXT_W-1:0] t_out,
    output logic [DATA_W-1:0] q_out,
    output logic [TAG_W-1:0]  tag_out
);

    logic [W-1:0]      tl;
    logic [W-1:0]      t;
    logic [NEXT_W-1:0] t_next;

    assign tl = t_in[W-1:0];
    assign t  = -tl;
    // (T + q*t) / 2^W without the wide add: the low word sums to 0 or exactly 2^W.
    assign t_next = NEXT_W'(t_in[CURR_W-1:W])
                  + NEXT_W'(q_in[DATA_W-1:W]) * NEXT_W'(t)
                  + NEXT_W'(tl != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out <= 1'b0;
        end else if (ce) begin
            valid_out <= valid_in;
        end
    end

    // NOTE: datapath registers are deliberately not reset; the valid bit alone qualifies them.
    always_ff @(posedge clk) begin
        if (ce) begin
            t_out   <= t_next;
            q_out   <= q_in;
            tag_out <= tag_in;
`ifdef MODRED_CHECK_EN
            err_out <= err_in;
`endif
        end
    end

endmodule

// File: rtl/modred_pipe.sv
// Pipelined modular reducer: out_c = in_p * 2^(-L*W) mod in_q, whole-pipe stall on out_ready.
// Build option: MODRED_CHECK_EN enables out_err for moduli with in_q[W-1:0] != 1 or in_q == 0.
module modred_pipe
    import modred_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int W      = W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_q,
    input  logic [2*DATA_W-1:0] in_p,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_c,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_err
);

    localparam int NSTG = n_stages(DATA_W, W);
    localparam int VW   = cw(NSTG, DATA_W, W);

    logic ce;
    assign ce       = ~out_valid | out_ready;
    assign in_ready = ce;

    logic [NSTG:0]             valid_p;
    logic [NSTG:0][DATA_W-1:0] q_p;
    logic [NSTG:0][TAG_W-1:0]  tag_p;

    assign valid_p[0] = in_valid;
    assign q_p[0]     = in_q;
    assign tag_p[0]   = in_tag;

`ifdef MODRED_CHECK_EN
    logic [NSTG:0] err_p;
    assign err_p[0] = (in_q[W-1:0] != W'(1)) || (in_q == '0);
`endif

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        localparam int CW = cw(k, DATA_W, W);
        localparam int NW = cw(k + 1, DATA_W, W);

        logic [CW-1:0] t_i;
        logic [NW-1:0] t_o;

        if (k == 0) begin : g_in
            assign t_i = in_p;
        end else begin : g_chain
            assign t_i = g_stage[k-1].t_o;
        end

        modred_stage #(
            .CURR_W (CW),
            .NEXT_W (NW),
            .DATA_W (DATA_W),
            .W      (W),
            .TAG_W  (TAG_W)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .ce        (ce),
            .valid_in  (valid_p[k]),
            .t_in      (t_i),
            .q_in      (q_p[k]),
            .tag_in    (tag_p[k]),
`ifdef MODRED_CHECK_EN
            .err_in    (err_p[k]),
            .err_out   (err_p[k+1]),
`endif
            .valid_out (valid_p[k+1]),
            .t_out     (t_o),
            .q_out     (q_p[k+1]),
            .tag_out   (tag_p[k+1])
        );
    end

    // V < 3q, so subtracting 0, q or 2q lands in [0, q).
    logic [VW-1:0]     v;
    logic [VW-1:0]     q1;
    logic [VW-1:0]     q2;
    logic [VW-1:0]     sub;
    logic [DATA_W-1:0] c_next;

    assign v  = g_stage[NSTG-1].t_o;
    assign q1 = VW'(q_p[NSTG]);
    assign q2 = VW'({q_p[NSTG], 1'b0});

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        sub = '0;
        if (v >= q2) begin
            sub = q2;
        end else if (v >= q1) begin
            sub = q1;
        end
        c_next = DATA_W'(v - sub);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_c     <= '0;
            out_tag   <= '0;
        end else if (ce) begin
            out_valid <= valid_p[NSTG];
            out_c     <= c_next;
            out_tag   <= tag_p[NSTG];
        end
    end

`ifdef MODRED_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_err <= 1'b0;
        end else if (ce) begin
            out_err <= err_p[NSTG];
        end
    end
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_modred_pipe.sv
// Scoreboard bench for modred_pipe; model reduces P mod q then halves mod q thirty times.
module tb_modred_pipe;

    localparam int DATA_W = 30;
    localparam int TAG_W  = 8;
    localparam logic [29:0] Q0 = 30'd1073479681;

    typedef struct {
        logic [DATA_W-1:0] c;
        logic [TAG_W-1:0]  tag;
        logic              err;
        bit                chk_c;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [DATA_W-1:0]   in_q = '0;
    logic [2*DATA_W-1:0] in_p = '0;
    logic [TAG_W-1:0]    in_tag = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [DATA_W-1:0]   out_c;
    logic [TAG_W-1:0]    out_tag;
    logic                out_err;

    int   passed = 0;
    int   total  = 0;
    int   n_out  = 0;
    int   acc    = 0;
    bit   last_acc;
    exp_t sb[$];
    exp_t cur_exp;
    exp_t mon_e;

    modred_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_q      (in_q),
        .in_p      (in_p),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic logic [DATA_W-1:0] model(input logic [63:0] p, input logic [DATA_W-1:0] q);
        logic [63:0] x;
        x = p % {34'd0, q};
        for (int i = 0; i < 30; i++) begin
            if (x[0]) x = x + {34'd0, q};
            x = x >> 1;
        end
        return x[DATA_W-1:0];
    endfunction

    function automatic logic q_bad(input logic [DATA_W-1:0] q);
        return (q[5:0] != 6'd1) || (q == '0);
    endfunction

    function automatic logic [DATA_W-1:0] rand_q();
        logic [23:0] hi;
        hi = 24'($urandom_range(1, (1 << 24) - 1));
        return {hi, 6'b000001};
    endfunction

    task automatic set_beat(input logic [63:0] p, input logic [DATA_W-1:0] q, input logic [TAG_W-1:0] tag);
        in_p     = 60'(p);
        in_q     = q;
        in_tag   = tag;
        in_valid = 1'b1;
        cur_exp.c     = model(p, q);
        cur_exp.tag   = tag;
        cur_exp.chk_c = !q_bad(q);
`ifdef MODRED_CHECK_EN
        cur_exp.err   = q_bad(q);
`else
        cur_exp.err   = 1'b0;
`endif
    endtask

    task automatic set_random_beat();
        logic [DATA_W-1:0] q;
        logic [63:0]       qq;
        logic [63:0]       p;
        q  = rand_q();
        qq = 64'(q) * 64'(q);
        p  = {$urandom, $urandom} % qq;
        set_beat(p, q, TAG_W'($urandom));
    endtask

    // One clock: record acceptance at the falling edge, return 1 ns after the rising edge.
    task automatic step();
        @(negedge clk);
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            sb.push_back(cur_exp);
            acc++;
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            n_out++;
            total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_output: got c=%0d tag=%h, required no output", out_c, out_tag);
            end else begin
                mon_e = sb.pop_front();
                if ((mon_e.chk_c && out_c !== mon_e.c) || out_tag !== mon_e.tag || out_err !== mon_e.err)
                    $display("FAIL scoreboard: got c=%0d tag=%h err=%b, required c=%0d tag=%h err=%b",
                             out_c, out_tag, out_err, mon_e.c, mon_e.tag, mon_e.err);
                else
                    passed++;
            end
        end
    end

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) step();
        total++;
        if (sb.size() !== 0)
            $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
        else
            passed++;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (out_valid !== 1'b0 || out_c !== '0 || out_tag !== '0 || out_err !== 1'b0)
            $display("FAIL reset_state: got v=%b c=%0d tag=%h err=%b, required all 0",
                     out_valid, out_c, out_tag, out_err);
        else
            passed++;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", in_ready);
        else passed++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [63:0]       p_tab[4]   = '{64'd262143, 64'd1310715, 64'd0, 64'(Q0)};
        logic [DATA_W-1:0] c_tab[4]   = '{30'd1, 30'd5, 30'd0, 30'd0};
        logic [TAG_W-1:0]  tag_tab[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_beat(p_tab[i], Q0, tag_tab[i]);
            step();
            in_valid = 1'b0;
            repeat (4) step();
            total++;
            if (out_valid !== 1'b0) $display("FAIL latency_early_%0d: got out_valid=%b, required 0", i, out_valid);
            else passed++;
            step();
            total++;
            if (out_valid !== 1'b1 || out_c !== c_tab[i] || out_tag !== tag_tab[i])
                $display("FAIL directed_%0d: got v=%b c=%0d tag=%h, required v=1 c=%0d tag=%h",
                         i, out_valid, out_c, out_tag, c_tab[i], tag_tab[i]);
            else
                passed++;
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int n0;
        int a0;
        n0 = n_out;
        a0 = acc;
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            set_random_beat();
            step();
        end
        in_valid = 1'b0;
        repeat (5) step();
        @(negedge clk);
        #1;
        total++;
        if (acc - a0 !== 1000) $display("FAIL b2b_accept: got %0d, required 1000", acc - a0);
        else passed++;
        total++;
        if (n_out - n0 !== 1000 || sb.size() !== 0)
            $display("FAIL b2b_throughput: got %0d outputs %0d pending, required 1000 and 0", n_out - n0, sb.size());
        else
            passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        int a0;
        int n0;
        logic [DATA_W-1:0] c_s;
        logic [TAG_W-1:0]  t_s;
        logic              e_s;
        out_ready = 1'b0;
        a0 = acc;
        last_acc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (last_acc) set_random_beat();
            step();
        end
        in_valid = 1'b0;
        total++;
        if (acc - a0 !== 6) $display("FAIL stall_fill: got %0d accepted, required 6", acc - a0);
        else passed++;
        c_s = out_c;
        t_s = out_tag;
        e_s = out_err;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_c !== c_s || out_tag !== t_s || out_err !== e_s)
                $display("FAIL stall_hold_%0d: got rdy=%b v=%b c=%0d tag=%h, required rdy=0 v=1 c=%0d tag=%h",
                         i, in_ready, out_valid, out_c, out_tag, c_s, t_s);
            else
                passed++;
        end
        n0 = n_out;
        out_ready = 1'b1;
        repeat (8) step();
        total++;
        if (n_out - n0 !== 6 || sb.size() !== 0)
            $display("FAIL stall_release: got %0d outputs %0d pending, required 6 and 0", n_out - n0, sb.size());
        else
            passed++;
    endtask

    task automatic test_random_toggle();
        int a0;
        a0 = acc;
        last_acc = 1'b1;
        for (int cyc = 0; cyc < 5000 && (acc - a0) < 300; cyc++) begin
            if (last_acc) set_random_beat();
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        total++;
        if (acc - a0 !== 300) $display("FAIL toggle_accept: got %0d, required 300", acc - a0);
        else passed++;
        drain();
    endtask

    task automatic test_reset_midstream();
        int n0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_random_beat();
            step();
        end
        in_valid = 1'b0;
        reset = 1'b0;
        sb.delete();
        #1;
        total++;
        if (out_valid !== 1'b0 || out_c !== '0 || out_tag !== '0)
            $display("FAIL reset_flush: got v=%b c=%0d tag=%h, required all 0", out_valid, out_c, out_tag);
        else
            passed++;
        @(posedge clk);
        #2;
        reset = 1'b1;
        n0 = n_out;
        set_beat(64'd262143, Q0, 8'h5A);
        step();
        in_valid = 1'b0;
        repeat (5) step();
        total++;
        if (out_valid !== 1'b1 || out_c !== 30'd1 || out_tag !== 8'h5A)
            $display("FAIL reset_resume: got v=%b c=%0d tag=%h, required v=1 c=1 tag=5a", out_valid, out_c, out_tag);
        else
            passed++;
        drain();
        repeat (8) step();
        total++;
        if (n_out - n0 !== 1) $display("FAIL reset_ghost: got %0d outputs, required 1", n_out - n0);
        else passed++;
    endtask

    task automatic test_err();
        out_ready = 1'b1;
        set_beat(64'd262143, Q0, 8'hA1);
        step();
        set_beat(64'd1310715, 30'd1073479683, 8'hA2);
        step();
        set_beat(64'd1310715, Q0, 8'hA3);
        step();
        in_valid = 1'b0;
        repeat (5) step();
        total++;
        if (out_valid !== 1'b1 || out_tag !== 8'hA3 || out_err !== 1'b0 || out_c !== 30'd5)
            $display("FAIL err_neighbour: got v=%b tag=%h err=%b c=%0d, required v=1 tag=a3 err=0 c=5",
                     out_valid, out_tag, out_err, out_c);
        else
            passed++;
        drain();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_random_toggle();
        test_reset_midstream();
        test_err();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
